// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Two-port (fetch, load/store) arbiter onto one memory port with a
//            single outstanding transaction. Define ARB_RR_EN for round-robin
//            arbitration; otherwise load/store has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    // fetch port
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [63:0] if_rdata,
    // load/store port
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [63:0] ls_addr,
    input  logic [63:0] ls_wdata,
    input  logic [7:0]  ls_be,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [63:0] ls_rdata,
    // memory port
    output logic        ram_req,
    output logic        ram_we,
    output logic [63:0] ram_addr,
    output logic [63:0] ram_wdata,
    output logic [7:0]  ram_be,
    input  logic        ram_ready,
    input  logic        ram_rvalid,
    input  logic [63:0] ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [7:0] c_FETCH_BE = 8'hFF;

    state_t      r_state;
    logic        r_owner_ls;
    logic        r_we;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [7:0]  r_be;
    logic [63:0] r_rsp;

    logic        w_idle;
    logic        w_grant_if;
    logic        w_grant_ls;

    // Gated with rst_n so no grant is visible while reset is held.
    assign w_idle = (r_state == S_IDLE) && rst_n;

`ifdef ARB_RR_EN
    logic r_last_ls;

    // On a tie, the requester that was not granted last wins.
    assign w_grant_ls = w_idle && ls_req && (!if_req || !r_last_ls);
    assign w_grant_if = w_idle && if_req && (!ls_req ||  r_last_ls);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_ls <= 1'b0;
        end else if (w_grant_ls || w_grant_if) begin
            r_last_ls <= w_grant_ls;
        end
    end
`else
    assign w_grant_ls = w_idle && ls_req;
    assign w_grant_if = w_idle && if_req && !ls_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_owner_ls <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 64'd0;
            r_wdata    <= 64'd0;
            r_be       <= 8'd0;
            r_rsp      <= 64'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_ls) begin
                        r_owner_ls <= 1'b1;
                        r_we       <= ls_we;
                        r_addr     <= ls_addr;
                        r_wdata    <= ls_wdata;
                        r_be       <= ls_be;
                        r_state    <= S_ISSUE;
                    end else if (w_grant_if) begin
                        r_owner_ls <= 1'b0;
                        r_we       <= 1'b0;
                        r_addr     <= if_addr;
                        r_wdata    <= 64'd0;
                        r_be       <= c_FETCH_BE;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (ram_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Writes return an ack only; their response data is zero.
                    if (ram_rvalid) begin
                        r_rsp   <= r_we ? 64'd0 : ram_rdata;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign if_gnt    = w_grant_if;
    assign ls_gnt    = w_grant_ls;

    assign ram_req   = (r_state == S_ISSUE);
    assign ram_we    = r_we;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign ram_be    = r_be;

    assign if_rvalid = (r_state == S_RESP) && !r_owner_ls;
    assign ls_rvalid = (r_state == S_RESP) &&  r_owner_ls;
    assign if_rdata  = r_rsp;
    assign ls_rdata  = r_rsp;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter (honours ARB_RR_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [63:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [63:0] ls_addr;
    logic [63:0] ls_wdata;
    logic [7:0]  ls_be;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [63:0] ls_rdata;
    logic        ram_req;
    logic        ram_we;
    logic [63:0] ram_addr;
    logic [63:0] ram_wdata;
    logic [7:0]  ram_be;
    logic        ram_ready;
    logic        ram_rvalid;
    logic [63:0] ram_rdata;

    int n_pass  = 0;
    int n_total = 0;

    mem_port_arbiter u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .ls_req     (ls_req),
        .ls_we      (ls_we),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_be      (ls_be),
        .ls_gnt     (ls_gnt),
        .ls_rvalid  (ls_rvalid),
        .ls_rdata   (ls_rdata),
        .ram_req    (ram_req),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_be     (ram_be),
        .ram_ready  (ram_ready),
        .ram_rvalid (ram_rvalid),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_req = 1'b1; ls_req = 1'b1;
        if_addr = 64'h1111; ls_addr = 64'h2222; ls_we = 1'b1; ls_wdata = 64'h3333; ls_be = 8'h0F;
        ram_ready = 1'b0; ram_rvalid = 1'b0; ram_rdata = 64'h4444;
        step(); step(); #1;
        if (if_gnt !== 1'b0) $display("FAIL rst_if_gnt: got %0h want 0", if_gnt); else n_pass++; n_total++;
        if (ls_gnt !== 1'b0) $display("FAIL rst_ls_gnt: got %0h want 0", ls_gnt); else n_pass++; n_total++;
        if (ram_req !== 1'b0) $display("FAIL rst_ram_req: got %0h want 0", ram_req); else n_pass++; n_total++;
        if (ram_we !== 1'b0) $display("FAIL rst_ram_we: got %0h want 0", ram_we); else n_pass++; n_total++;
        if (ram_addr !== 64'd0) $display("FAIL rst_ram_addr: got %0h want 0", ram_addr); else n_pass++; n_total++;
        if (ram_wdata !== 64'd0) $display("FAIL rst_ram_wdata: got %0h want 0", ram_wdata); else n_pass++; n_total++;
        if (ram_be !== 8'd0) $display("FAIL rst_ram_be: got %0h want 0", ram_be); else n_pass++; n_total++;
        if (if_rvalid !== 1'b0 || ls_rvalid !== 1'b0) $display("FAIL rst_rvalid: got %0h/%0h want 0/0", if_rvalid, ls_rvalid); else n_pass++; n_total++;
        if (if_rdata !== 64'd0 || ls_rdata !== 64'd0) $display("FAIL rst_rdata: got %0h/%0h want 0/0", if_rdata, ls_rdata); else n_pass++; n_total++;
        if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        step();
        if_req = 1'b1; if_addr = 64'h0000_0000_8000_0000;
        #1;
        if (if_gnt !== 1'b1) $display("FAIL fetch_gnt: got %0h want 1", if_gnt); else n_pass++; n_total++;
        if (ls_gnt !== 1'b0) $display("FAIL fetch_ls_gnt: got %0h want 0", ls_gnt); else n_pass++; n_total++;
        if (ram_req !== 1'b0) $display("FAIL fetch_c0_ram_req: got %0h want 0", ram_req); else n_pass++; n_total++;
        step();
        if_req = 1'b0; ram_ready = 1'b1;
        #1;
        if (ram_req !== 1'b1) $display("FAIL fetch_c1_ram_req: got %0h want 1", ram_req); else n_pass++; n_total++;
        if (ram_addr !== 64'h8000_0000) $display("FAIL fetch_ram_addr: got %0h want 80000000", ram_addr); else n_pass++; n_total++;
        if (ram_be !== 8'hFF) $display("FAIL fetch_ram_be: got %0h want ff", ram_be); else n_pass++; n_total++;
        if (ram_we !== 1'b0) $display("FAIL fetch_ram_we: got %0h want 0", ram_we); else n_pass++; n_total++;
        if (ram_wdata !== 64'd0) $display("FAIL fetch_ram_wdata: got %0h want 0", ram_wdata); else n_pass++; n_total++;
        step();
        ram_ready = 1'b0; ram_rvalid = 1'b1; ram_rdata = 64'h0000_0013_0000_0093;
        #1;
        if (ram_req !== 1'b0) $display("FAIL fetch_c2_ram_req: got %0h want 0", ram_req); else n_pass++; n_total++;
        step();
        ram_rvalid = 1'b0; ram_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        if (if_rvalid !== 1'b1) $display("FAIL fetch_c3_rvalid: got %0h want 1", if_rvalid); else n_pass++; n_total++;
        if (if_rdata !== 64'h0000_0013_0000_0093) $display("FAIL fetch_rdata: got %0h want 0000001300000093", if_rdata); else n_pass++; n_total++;
        if (ls_rvalid !== 1'b0) $display("FAIL fetch_ls_rvalid: got %0h want 0", ls_rvalid); else n_pass++; n_total++;
        if (ls_rdata !== 64'h0000_0013_0000_0093) $display("FAIL fetch_ls_rdata: got %0h want 0000001300000093", ls_rdata); else n_pass++; n_total++;
        step(); #1;
        if (if_rvalid !== 1'b0) $display("FAIL fetch_c4_rvalid: got %0h want 0", if_rvalid); else n_pass++; n_total++;
    endtask

    task automatic test_store();
        step();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 64'h8000_1004;
        ls_wdata = 64'hDEAD_BEEF_0000_0000; ls_be = 8'hF0;
        #1;
        if (ls_gnt !== 1'b1) $display("FAIL store_gnt: got %0h want 1", ls_gnt); else n_pass++; n_total++;
        step();
        ls_req = 1'b0; if_req = 1'b1; ls_addr = 64'd0; ls_wdata = 64'd0; ls_be = 8'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (ram_req !== 1'b1) $display("FAIL store_hold_req[%0d]: got %0h want 1", i, ram_req); else n_pass++; n_total++;
            if (ram_we !== 1'b1 || ram_addr !== 64'h8000_1004 || ram_wdata !== 64'hDEAD_BEEF_0000_0000 || ram_be !== 8'hF0)
                $display("FAIL store_fields[%0d]: got we=%0h a=%0h d=%0h be=%0h want 1/80001004/deadbeef00000000/f0", i, ram_we, ram_addr, ram_wdata, ram_be);
            else n_pass++;
            n_total++;
            if (if_gnt !== 1'b0) $display("FAIL store_busy_if_gnt[%0d]: got %0h want 0", i, if_gnt); else n_pass++; n_total++;
            step();
        end
        ram_ready = 1'b1;
        #1;
        if (ram_req !== 1'b1) $display("FAIL store_c4_ram_req: got %0h want 1", ram_req); else n_pass++; n_total++;
        step();
        ram_ready = 1'b0; if_req = 1'b0; ram_rvalid = 1'b1; ram_rdata = 64'h1234_5678_9ABC_DEF0;
        #1;
        if (ram_req !== 1'b0) $display("FAIL store_wait_ram_req: got %0h want 0", ram_req); else n_pass++; n_total++;
        step();
        ram_rvalid = 1'b0;
        #1;
        if (ls_rvalid !== 1'b1) $display("FAIL store_rvalid: got %0h want 1", ls_rvalid); else n_pass++; n_total++;
        if (ls_rdata !== 64'd0) $display("FAIL store_rdata: got %0h want 0", ls_rdata); else n_pass++; n_total++;
        if (if_rvalid !== 1'b0) $display("FAIL store_if_rvalid: got %0h want 0", if_rvalid); else n_pass++; n_total++;
        step(); #1;
        if (ls_rvalid !== 1'b0) $display("FAIL store_rvalid_once: got %0h want 0", ls_rvalid); else n_pass++; n_total++;
        ls_we = 1'b0;
    endtask

    task automatic test_arbitration();
        logic exp_ls;
        step();
        rst_n = 1'b0; #1; rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
            exp_ls = (k % 2 == 0);
`else
            exp_ls = 1'b1;
`endif
            if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0;
            if_addr = 64'h100 + 64'(k); ls_addr = 64'h200 + 64'(k);
            #1;
            if (ls_gnt !== exp_ls || if_gnt !== !exp_ls)
                $display("FAIL arb_gnt[%0d]: got ls=%0h if=%0h want ls=%0h if=%0h", k, ls_gnt, if_gnt, exp_ls, !exp_ls);
            else n_pass++;
            n_total++;
            step();
            ram_ready = 1'b1;
            #1;
            if (ls_gnt !== 1'b0 || if_gnt !== 1'b0) $display("FAIL arb_busy_gnt[%0d]: got %0h/%0h want 0/0", k, ls_gnt, if_gnt); else n_pass++; n_total++;
            if (ram_addr !== (exp_ls ? 64'h200 + 64'(k) : 64'h100 + 64'(k)))
                $display("FAIL arb_addr[%0d]: got %0h want %0h", k, ram_addr, exp_ls ? 64'h200 + 64'(k) : 64'h100 + 64'(k));
            else n_pass++;
            n_total++;
            step();
            ram_ready = 1'b0; ram_rvalid = 1'b1; ram_rdata = 64'hA0 + 64'(k);
            step();
            ram_rvalid = 1'b0;
            #1;
            if (ls_rvalid !== exp_ls || if_rvalid !== !exp_ls)
                $display("FAIL arb_rvalid[%0d]: got ls=%0h if=%0h want ls=%0h if=%0h", k, ls_rvalid, if_rvalid, exp_ls, !exp_ls);
            else n_pass++;
            n_total++;
            if (ls_rdata !== 64'hA0 + 64'(k)) $display("FAIL arb_rdata[%0d]: got %0h want %0h", k, ls_rdata, 64'hA0 + 64'(k)); else n_pass++; n_total++;
            step();
        end
        if_req = 1'b0; ls_req = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        step();
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h8000_0010;
        #1;
        if (ls_gnt !== 1'b1) $display("FAIL rmw_gnt: got %0h want 1", ls_gnt); else n_pass++; n_total++;
        step();
        ls_req = 1'b0; ram_ready = 1'b1;
        step();
        ram_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        if (ram_addr !== 64'd0 || ram_req !== 1'b0 || ram_be !== 8'd0)
            $display("FAIL rmw_abort: got a=%0h req=%0h be=%0h want 0/0/0", ram_addr, ram_req, ram_be);
        else n_pass++;
        n_total++;
        step();
        rst_n = 1'b1; ram_rvalid = 1'b1; ram_rdata = 64'h5555_AAAA_5555_AAAA;
        #1;
        if (ram_addr !== 64'd0 || ram_req !== 1'b0) $display("FAIL rmw_idle: got a=%0h req=%0h want 0/0", ram_addr, ram_req); else n_pass++; n_total++;
        step();
        ram_rvalid = 1'b0;
        #1;
        if (ls_rvalid !== 1'b0 || ls_rdata !== 64'd0) $display("FAIL rmw_no_resp: got v=%0h d=%0h want 0/0", ls_rvalid, ls_rdata); else n_pass++; n_total++;
        step(); #1;
        if (ls_rvalid !== 1'b0) $display("FAIL rmw_no_resp_late: got %0h want 0", ls_rvalid); else n_pass++; n_total++;
    endtask

    task automatic test_rvalid_in_issue();
        step();
        if_req = 1'b1; if_addr = 64'h8000_0040;
        #1;
        if (if_gnt !== 1'b1) $display("FAIL early_gnt: got %0h want 1", if_gnt); else n_pass++; n_total++;
        step();
        if_req = 1'b0; ram_ready = 1'b0; ram_rvalid = 1'b1; ram_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        #1;
        if (ram_req !== 1'b1) $display("FAIL early_issue_req: got %0h want 1", ram_req); else n_pass++; n_total++;
        step();
        ram_rvalid = 1'b0; ram_ready = 1'b1;
        #1;
        if (ram_req !== 1'b1) $display("FAIL early_still_issue: got %0h want 1", ram_req); else n_pass++; n_total++;
        step();
        ram_ready = 1'b0; ram_rvalid = 1'b1; ram_rdata = 64'h0600_0D0D_0600_0D0D;
        #1;
        if (ram_req !== 1'b0 || if_rvalid !== 1'b0) $display("FAIL early_wait: got req=%0h v=%0h want 0/0", ram_req, if_rvalid); else n_pass++; n_total++;
        step();
        ram_rvalid = 1'b0;
        #1;
        if (if_rvalid !== 1'b1) $display("FAIL early_rvalid: got %0h want 1", if_rvalid); else n_pass++; n_total++;
        if (if_rdata !== 64'h0600_0D0D_0600_0D0D) $display("FAIL early_rdata: got %0h want 06000d0d06000d0d", if_rdata); else n_pass++; n_total++;
        step(); #1;
        if (if_rvalid !== 1'b0) $display("FAIL early_rvalid_once: got %0h want 0", if_rvalid); else n_pass++; n_total++;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_arbitration();
        test_reset_mid_wait();
        test_rvalid_in_issue();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have: rst_n  in  1  asynchronous reset, active low.
REQ-003 SHALL have: if_req in 1 fetch request; if_addr in 64 fetch address; if_gnt out 1 fetch accepted; if_rvalid out 1 fetch data valid; if_rdata out 64 fetch data.
REQ-004 SHALL have: ls_req in 1 load/store request; ls_we in 1 store=1; ls_addr in 64; ls_wdata in 64; ls_be in 8 byte enables; ls_gnt out 1; ls_rvalid out 1; ls_rdata out 64.
REQ-005 SHALL have: ram_req out 1; ram_we out 1; ram_addr out 64; ram_wdata out 64; ram_be out 8; ram_ready in 1 (request accepted); ram_rvalid in 1 (read data/write ack); ram_rdata in 64.

Function
REQ-006 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, with one outstanding transaction.
REQ-007 In IDLE with any req, SHALL assert the winner's gnt combinationally that cycle, latch its addr/we/wdata/be and owner, and enter ISSUE next cycle; otherwise stay IDLE.
REQ-008 Fetch latch SHALL force we=0, wdata=0, be=8'hFF.
REQ-009 Outside IDLE, SHALL hold if_gnt=ls_gnt=0; requesters hold req until granted; req drop after gnt has no effect.
REQ-010 In ISSUE, SHALL drive ram_req=1 with latched fields; on ram_ready=1 go to WAIT, else stay.
REQ-011 ram_req SHALL be 0 in all other states; ram_* fields SHALL be the latched values at all times.
REQ-012 In WAIT, on ram_rvalid=1 SHALL capture ram_rdata (reads) or 0 (writes) into the response register and enter RESP; ram_rvalid outside WAIT SHALL be ignored.
REQ-013 In RESP, SHALL assert the owner's rvalid for exactly one cycle with rdata = captured value, then enter IDLE; non-owner rvalid=0.
REQ-014 if_rdata/ls_rdata SHALL both present the response register; only rvalid is owner-qualified.
REQ-015 Minimum latency: gnt cycle 0, ram_req cycle 1, ram_ready cycle 1, ram_rvalid cycle 2, rvalid cycle 3, next gnt cycle 4.
REQ-016 Arbitration without ARB_RR_EN: ls_req beats if_req when both asserted.

Reset
REQ-017 rst_n=0 SHALL immediately force state IDLE, all latched fields, response register, and last_owner (=fetch) to 0/reset values, aborting any transaction.
REQ-018 During and after reset until a grant: all gnt, rvalid, ram_req, ram_we = 0; ram_addr, ram_wdata, rdata = 0; ram_be = 0.

Configuration
REQ-019 Macro ARB_RR_EN defined: SHALL use round-robin; on simultaneous requests grant the requester not granted last; last_owner updates at each grant; reset last_owner=fetch (load/store wins first tie).
REQ-020 Macro ARB_RR_EN undefined: SHALL use fixed priority per REQ-016; no last_owner register.

Verification
REQ-021 Reset mid-WAIT (ls read 0x80000010 issued) -> next cycle all outputs 0, state IDLE, later ram_rvalid ignored, no ls_rvalid.
REQ-022 if_req only, addr 0x80000000, ram_ready=1 immediately, ram_rvalid cycle 2 with 0x00000013_00000093 -> if_gnt c0, ram_req c1 be=FF we=0, if_rvalid c3 with that data.
REQ-023 ls store addr 0x80001004, wdata 0xDEADBEEF_00000000, be 8'hF0, ram_ready low 3 cycles -> ram_req held 4 cycles with stable fields; ls_rvalid one cycle after ram_rvalid, ls_rdata=0.
REQ-024 if_req and ls_req together every IDLE, ARB_RR_EN off -> ls always granted; if_gnt never while ls_req high.
REQ-025 Same stimulus, ARB_RR_EN on -> grants alternate ls, if, ls, if.
REQ-026 ram_rvalid pulsed in ISSUE before ram_ready -> ignored; response only from ram_rvalid in WAIT.
